seg7_scan_driver: RTL and testbench

//  4-digit multiplexed 7-segment display driver; downstream consumer of the playground's
//  hex/value outputs (HEX7 nibble, FDC count, RAM data).

---
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with double-buffered value
module seg7_scan_driver #(
    parameter int PRESCALE = 12500,
    parameter int BLANK    = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    // Both buffers hold {dp[3:0], value[15:0]}
    logic [19:0]   pending;
    logic [19:0]   shadow;

    logic          last_cnt;
    logic          boundary;
    logic [3:0]    nibble;
    logic [3:0]    shadow_dp;
    logic          suppressed;
    logic          zero3;
    logic          zero2;
    logic          zero1;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    an_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b0111111;
            4'h1: hex_to_seg = 7'b0000110;
            4'h2: hex_to_seg = 7'b1011011;
            4'h3: hex_to_seg = 7'b1001111;
            4'h4: hex_to_seg = 7'b1100110;
            4'h5: hex_to_seg = 7'b1101101;
            4'h6: hex_to_seg = 7'b1111101;
            4'h7: hex_to_seg = 7'b0000111;
            4'h8: hex_to_seg = 7'b1111111;
            4'h9: hex_to_seg = 7'b1101111;
            4'hA: hex_to_seg = 7'b1110111;
            4'hB: hex_to_seg = 7'b1111100;
            4'hC: hex_to_seg = 7'b0111001;
            4'hD: hex_to_seg = 7'b1011110;
            4'hE: hex_to_seg = 7'b1111001;
            default: hex_to_seg = 7'b1110001;
        endcase
    endfunction

    assign last_cnt  = (cnt == CW'(PRESCALE - 1));
    assign boundary  = ena && last_cnt && (digit == 2'd3);
    assign shadow_dp = shadow[19:16];
    assign zero3     = (shadow[15:12] == 4'h0);
    assign zero2     = zero3 && (shadow[11:8] == 4'h0);
    assign zero1     = zero2 && (shadow[7:4] == 4'h0);

    // Slot decode: pick the nibble for the current digit, apply blanking and zero suppression
    always_comb begin
        nibble     = 4'h0;
        suppressed = 1'b0;
        seg_nxt    = 7'b0;
        dp_nxt     = 1'b0;
        an_nxt     = 4'b0;
        case (digit)
            2'd0: nibble = shadow[3:0];
            2'd1: nibble = shadow[7:4];
            2'd2: nibble = shadow[11:8];
            default: nibble = shadow[15:12];
        endcase
        case (digit)
            2'd1: suppressed = blank_lz && zero1;
            2'd2: suppressed = blank_lz && zero2;
            2'd3: suppressed = blank_lz && zero3;
            default: suppressed = 1'b0;
        endcase
        if (ena && (cnt >= CW'(BLANK))) begin
            dp_nxt = shadow_dp[digit];
            if (suppressed) begin
                // A suppressed digit still lights if its decimal point is set
                an_nxt[digit] = shadow_dp[digit];
            end else begin
                an_nxt[digit] = 1'b1;
                seg_nxt       = hex_to_seg(nibble);
            end
        end
    end

    // Slot counter and digit index; both hold while ena is low
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (ena) begin
            if (last_cnt) begin
                cnt   <= '0;
                digit <= digit + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Double buffer: loads land in pending, shadow only changes at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 20'h0;
            shadow  <= 20'h0;
        end else begin
            if (load) begin
                pending <= {dp_in, value_in};
            end
            if (boundary) begin
                shadow <= load ? {dp_in, value_in} : pending;
            end
        end
    end

    // Registered display outputs and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= 7'b0;
            dp         <= 1'b0;
            an         <= 4'b0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    logic [6:0] glyph [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    seg7_scan_driver #(.PRESCALE(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    // Advance until the next frame_done pulse (bounded)
    task automatic sync_frame;
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk_eq("sync_timeout", 0, 1);
    endtask

    // Check one whole frame, starting right after a frame_done pulse.
    // Compared word is {frame_done, an, dp, seg}. Optional load at iteration load_k.
    task automatic scan_frame(input string tag, input logic [15:0] an_p, input logic [27:0] seg_p,
                              input logic [3:0] dp_p, input int load_k,
                              input logic [15:0] lv, input logic [3:0] ld);
        int slot;
        int pos;
        logic [12:0] exp;
        for (int k = 1; k <= 32; k++) begin
            if (k == load_k) begin
                value_in = lv;
                dp_in    = ld;
                load     = 1'b1;
            end
            tick();
            load = 1'b0;
            slot = (k - 1) / 8;
            pos  = (k - 1) % 8;
            exp  = 13'b0;
            if (pos >= 2) exp[11:0] = {an_p[slot*4 +: 4], dp_p[slot], seg_p[slot*7 +: 7]};
            exp[12] = (k == 32);
            chk_eq(tag, {frame_done, an, dp, seg}, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; value_in = 16'h0; dp_in = 4'h0; load = 1'b0; blank_lz = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_eq("reset_outs", {frame_done, an, dp, seg}, 13'b0);

        // First active slot on the (BLANK+1)th edge after reset release
        rst = 1'b0;
        tick(); chk_eq("first_blank1", an, 4'b0000);
        tick(); chk_eq("first_blank2", an, 4'b0000);
        tick(); chk_eq("first_an", {an, seg}, {4'b0001, 7'b0111111});

        // 1: 0x1A3F, plain hex
        do_load(16'h1A3F, 4'h0);
        sync_frame();
        scan_frame("t1_1A3F", {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {7'b0000110, 7'b1110111, 7'b1001111, 7'b1110001}, 4'b0000, 0, 16'h0, 4'h0);

        // 2: leading-zero suppression, then dp on a suppressed digit
        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        sync_frame();
        scan_frame("t2_lz", {4'b0000, 4'b0000, 4'b0010, 4'b0001},
                   {7'b0, 7'b0, 7'b1101101, 7'b0111111}, 4'b0000, 0, 16'h0, 4'h0);
        do_load(16'h0050, 4'b0100);
        sync_frame();
        scan_frame("t2_lz_dp", {4'b0000, 4'b0100, 4'b0010, 4'b0001},
                   {7'b0, 7'b0, 7'b1101101, 7'b0111111}, 4'b0100, 0, 16'h0, 4'h0);
        blank_lz = 1'b0;

        // 3: tear-free update; mid-frame load waits, boundary-cycle load shows next frame
        do_load(16'h2222, 4'h0);
        sync_frame();
        scan_frame("t3_hold", {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {4{7'b1011011}}, 4'b0000, 10, 16'h1111, 4'h0);
        scan_frame("t3_new", {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {4{7'b0000110}}, 4'b0000, 32, 16'h3333, 4'h0);
        scan_frame("t3_bnd", {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                   {4{7'b1001111}}, 4'b0000, 0, 16'h0, 4'h0);

        // 4: ena low during digit 2
        repeat (20) tick();
        chk_eq("t4_pre", {an, seg}, {4'b0100, 7'b1001111});
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_eq("t4_off", {frame_done, an, dp, seg}, 13'b0);
        end
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_eq("t4_resume", {an, seg}, {4'b0100, 7'b1001111});
        end
        tick(); chk_eq("t4_blank_a", an, 4'b0000);
        tick(); chk_eq("t4_blank_b", an, 4'b0000);
        tick(); chk_eq("t4_digit3", {an, seg}, {4'b1000, 7'b1001111});

        // 5: reset during digit 1
        sync_frame();
        repeat (12) tick();
        chk_eq("t5_pre", an, 4'b0010);
        rst = 1'b1;
        tick();
        chk_eq("t5_rst", {frame_done, an, dp, seg}, 13'b0);
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk_eq("t5_no_fd", frame_done, 1'b0);
            if (k == 3)  chk_eq("t5_d0", {an, seg}, {4'b0001, 7'b0111111});
            if (k == 11) chk_eq("t5_d1", {an, seg}, {4'b0010, 7'b0111111});
        end

        // 6: glyph sweep on digit 0
        for (int v = 0; v < 16; v++) begin
            do_load({12'h0, 4'(v)}, 4'h0);
            sync_frame();
            for (int k = 1; k <= 8; k++) begin
                tick();
                chk_eq("t6_onehot", 32'($countones(an) <= 1), 1);
                if (k == 3) chk_eq($sformatf("t6_glyph_%0h", v), {an, seg}, {4'b0001, glyph[v]});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
